product_bcd_display: RTL and testbench
======================================

Name: product_bcd_display

Overview:
Downstream consumer of the 8x8 signed multiplier's 16-bit product ({Aval,Bval}). It converts the two's-complement product to sign + 5-digit BCD magnitude using an iterative shift-add-3 (double-dabble) sequencer. It registers the digits, a sign flag and a leading-zero blanking mask for the board hex displays. Conversion is started by a one-cycle Start pulse from the multiplier control after its final shift.

Parameters:
WIDTH, 16, product width in bits (signed two's complement)
DIGITS, 5, number of BCD output digits (must cover 2^(WIDTH-1))

Ports:
Clk  input  1  system clock, all state changes on rising edge
Reset  input  1  asynchronous, active-high; clears all state
Start  input  1  single-cycle request; Product sampled on the same edge
Product  input  WIDTH  signed product {Aval,Bval}
Busy  output  1  high while a conversion is in progress
Done  output  1  one-cycle pulse when new results are valid
Negative  output  1  registered sign of last converted product
BCD  output  4*DIGITS  registered magnitude digits; [3:0] = ones digit
DigitEn  output  DIGITS  registered leading-zero mask; bit i=1 if digit i is displayed

Behaviour:
- Reset (async, active-high): FSM to IDLE; Busy=0, Done=0, Negative=0, BCD=0, DigitEn=5'b00001, shift counter=0, scratch registers=0. Reset during CONV aborts; no Done pulse; outputs hold reset values.
- States: IDLE, CONV, DONE.
- IDLE: Busy=0. Start=1 at edge -> capture sign=Product[15] and mag = sign ? (~Product+1) : Product (16-bit unsigned; 16'h8000 gives mag 32768), clear 20-bit BCD scratch, counter=0, go CONV.
- CONV: Busy=1. Each edge: for each scratch digit >=5 add 3 (per digit, no carry between digits), then shift {scratch,mag} left one bit; counter++. Exactly WIDTH=16 iterations.
- On the 16th CONV edge: write final scratch to BCD, sign to Negative, computed mask to DigitEn; go DONE.
- DONE: Done=1, Busy=0 for exactly one cycle; next edge -> IDLE.
- Latency: Start sampled at edge 0; outputs updated at edge 16; Done high in the cycle between edges 16 and 17.
- Start while in CONV or DONE is ignored (no queueing, no restart). Product changes after the Start edge have no effect.
- DigitEn: bit 0 always 1. Bit i (i>0) is 1 iff any digit j>=i is nonzero.
- Negative for zero product is 0. No overflow is possible: max magnitude is 32768.
- Outputs BCD/Negative/DigitEn hold the last result until the next completion. They never show partial values.

Test Plan:
- Reset then Start with Product=16'h0000 -> Done at 17th cycle after Start edge; BCD=20'h00000, Negative=0, DigitEn=5'b00001.
- Product=16'h3039 (12345) -> BCD=20'h12345, Negative=0, DigitEn=5'b11111; Busy high exactly 16 cycles.
- Product=16'hFFCF (8'hF9*8'h07 = -49) -> BCD=20'h00049, Negative=1, DigitEn=5'b00011. Product=16'hFFFF -> BCD=20'h00001, Negative=1.
- Product=16'h8000 -> BCD=20'h32768, Negative=1. Product=16'h7FFF -> BCD=20'h32767, Negative=0.
- Second Start at cycle 5 of CONV with different Product -> ignored; result matches first Product; exactly one Done pulse.
- Assert Reset at cycle 8 of CONV, after a prior result 20'h00049 -> outputs immediately return to reset values; no Done; next Start converts normally.

Source files
------------

// File: rtl/product_bcd_display.sv
// ----------------------------------------------------------------------------
// product_bcd_display
//
// Converts the signed product of the 8x8 multiplier into a sign flag and a
// DIGITS-digit BCD magnitude for the board hex displays. The conversion uses an
// iterative shift-add-3 (double-dabble) sequencer, one bit per clock, so a
// result appears WIDTH clocks after the Start edge. BCD/Negative/DigitEn are
// only written when a conversion completes, so the display never shows
// partial values.
//
// Handshake: Start is a single-cycle request. It is accepted only while the
// FSM is in IDLE (Busy=0, Done=0); Product is sampled on that same edge.
// Busy is high for exactly WIDTH cycles, after which Done pulses for one
// cycle and the new outputs are valid. Start during CONV or DONE is dropped.
//
// Ports:
//   Clk      - system clock, rising edge
//   Reset    - asynchronous, active-high; clears all state
//   Start    - single-cycle conversion request
//   Product  - signed two's-complement product {Aval,Bval}
//   Busy     - high while a conversion is in progress
//   Done     - one-cycle pulse when new results are valid
//   Negative - registered sign of the last converted product
//   BCD      - registered magnitude digits, [3:0] = ones digit
//   DigitEn  - registered leading-zero mask, bit i=1 if digit i is displayed
// ----------------------------------------------------------------------------
module product_bcd_display #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [WIDTH-1:0]      Product,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Negative,
  output logic [4*DIGITS-1:0]   BCD,
  output logic [DIGITS-1:0]     DigitEn
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  sign_q, sign_d;
  logic [WIDTH-1:0]      mag_q, mag_d;
  logic [4*DIGITS-1:0]   scr_q, scr_d;
  logic                  neg_q, neg_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic [DIGITS-1:0]     en_q, en_d;

  // Datapath helpers for one double-dabble step.
  logic [4*DIGITS-1:0]   scr_adj;
  logic [4*DIGITS-1:0]   scr_shift;
  logic [DIGITS-1:0]     mask;
  logic                  any_nz;
  logic [WIDTH-1:0]      prod_abs;

  // Magnitude as unsigned; the most negative product maps to 2^(WIDTH-1).
  assign prod_abs = Product[WIDTH-1] ? ((~Product) + {{(WIDTH-1){1'b0}}, 1'b1})
                                     : Product;

  // Add 3 to every digit >= 5 independently, then shift in the next mag bit.
  always_comb begin
    scr_adj = scr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
    end
    scr_shift = {scr_adj[4*DIGITS-2:0], mag_q[WIDTH-1]};
  end

  // Leading-zero mask of the value being committed: digit i is shown if it
  // or any more-significant digit is nonzero; the ones digit always shows.
  always_comb begin
    mask   = '0;
    any_nz = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      any_nz  = any_nz | (scr_shift[4*i +: 4] != 4'd0);
      mask[i] = any_nz;
    end
    mask[0] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    scr_d   = scr_q;
    neg_d   = neg_q;
    bcd_d   = bcd_q;
    en_d    = en_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          sign_d  = Product[WIDTH-1];
          mag_d   = prod_abs;
          scr_d   = '0;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        scr_d = scr_shift;
        mag_d = {mag_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          bcd_d   = scr_shift;
          neg_d   = sign_q;
          en_d    = mask;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      scr_q   <= '0;
      neg_q   <= 1'b0;
      bcd_q   <= '0;
      en_q    <= {{(DIGITS-1){1'b0}}, 1'b1};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      scr_q   <= scr_d;
      neg_q   <= neg_d;
      bcd_q   <= bcd_d;
      en_q    <= en_d;
    end
  end

  assign Busy     = (state_q == CONV);
  assign Done     = (state_q == DONE);
  assign Negative = neg_q;
  assign BCD      = bcd_q;
  assign DigitEn  = en_q;

endmodule

// File: tb/tb_product_bcd_display.sv
// ----------------------------------------------------------------------------
// tb_product_bcd_display
//
// Directed test of product_bcd_display. Inputs change on the falling edge and
// outputs are sampled on the falling edge, half a period away from the active
// rising edge. Each scenario is its own task with inline comparisons against
// hand-computed BCD values.
// ----------------------------------------------------------------------------
module tb_product_bcd_display;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [15:0] Product;
  logic        Busy;
  logic        Done;
  logic        Negative;
  logic [19:0] BCD;
  logic [4:0]  DigitEn;

  int checks;
  int errors;

  product_bcd_display #(.WIDTH(16), .DIGITS(5)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .Product  (Product),
    .Busy     (Busy),
    .Done     (Done),
    .Negative (Negative),
    .BCD      (BCD),
    .DigitEn  (DigitEn)
  );

  // Clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Driver: one-cycle Start pulse. Returns at the falling edge right after
  // the edge that sampled Start.
  task automatic start_conv(input logic [15:0] p);
    @(negedge Clk);
    Start   = 1'b1;
    Product = p;
    @(negedge Clk);
    Start   = 1'b0;
    Product = 16'h0000;
  endtask

  // Driver: wait (bounded) for Done. cycles counts falling edges after the
  // one following the Start edge; busy_cnt counts falling edges with Busy=1.
  task automatic wait_done(output int cycles, output int busy_cnt, output bit seen);
    cycles   = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (Done) begin
        seen = 1'b1;
        break;
      end
      if (Busy) busy_cnt++;
      @(negedge Clk);
      cycles++;
    end
  endtask

  task automatic test_reset;
    Reset   = 1'b1;
    Start   = 1'b0;
    Product = 16'h0000;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", Done); end
    checks++; if (Negative !== 1'b0) begin errors++; $display("FAIL reset_neg got %b exp 0", Negative); end
    checks++; if (BCD !== 20'h00000) begin errors++; $display("FAIL reset_bcd got %h exp 00000", BCD); end
    checks++; if (DigitEn !== 5'b00001) begin errors++; $display("FAIL reset_en got %b exp 00001", DigitEn); end
  endtask

  task automatic test_zero;
    int cyc, bc; bit seen;
    start_conv(16'h0000);
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL zero_busy_start got %b exp 1", Busy); end
    wait_done(cyc, bc, seen);
    checks++; if (!seen) begin errors++; $display("FAIL zero_timeout no Done within 40 cycles"); end
    checks++; if (cyc != 16) begin errors++; $display("FAIL zero_latency got %0d exp 16", cyc); end
    checks++; if (BCD !== 20'h00000) begin errors++; $display("FAIL zero_bcd got %h exp 00000", BCD); end
    checks++; if (Negative !== 1'b0) begin errors++; $display("FAIL zero_neg got %b exp 0", Negative); end
    checks++; if (DigitEn !== 5'b00001) begin errors++; $display("FAIL zero_en got %b exp 00001", DigitEn); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL zero_busy_done got %b exp 0", Busy); end
    @(negedge Clk);
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL zero_done_width got %b exp 0", Done); end
  endtask

  task automatic test_positive;
    int cyc, bc; bit seen;
    start_conv(16'h3039);
    wait_done(cyc, bc, seen);
    checks++; if (!seen) begin errors++; $display("FAIL pos_timeout no Done within 40 cycles"); end
    checks++; if (bc != 16) begin errors++; $display("FAIL pos_busy_cycles got %0d exp 16", bc); end
    checks++; if (BCD !== 20'h12345) begin errors++; $display("FAIL pos_bcd got %h exp 12345", BCD); end
    checks++; if (Negative !== 1'b0) begin errors++; $display("FAIL pos_neg got %b exp 0", Negative); end
    checks++; if (DigitEn !== 5'b11111) begin errors++; $display("FAIL pos_en got %b exp 11111", DigitEn); end
  endtask

  task automatic test_negative;
    int cyc, bc; bit seen;
    start_conv(16'hFFCF);
    wait_done(cyc, bc, seen);
    checks++; if (!seen) begin errors++; $display("FAIL neg49_timeout no Done within 40 cycles"); end
    checks++; if (BCD !== 20'h00049) begin errors++; $display("FAIL neg49_bcd got %h exp 00049", BCD); end
    checks++; if (Negative !== 1'b1) begin errors++; $display("FAIL neg49_neg got %b exp 1", Negative); end
    checks++; if (DigitEn !== 5'b00011) begin errors++; $display("FAIL neg49_en got %b exp 00011", DigitEn); end
    start_conv(16'hFFFF);
    repeat (6) @(negedge Clk);
    // Mid-conversion the registered outputs must still show the previous result.
    checks++; if (BCD !== 20'h00049) begin errors++; $display("FAIL hold_bcd got %h exp 00049", BCD); end
    checks++; if (DigitEn !== 5'b00011) begin errors++; $display("FAIL hold_en got %b exp 00011", DigitEn); end
    wait_done(cyc, bc, seen);
    checks++; if (!seen) begin errors++; $display("FAIL neg1_timeout no Done within 40 cycles"); end
    checks++; if (BCD !== 20'h00001) begin errors++; $display("FAIL neg1_bcd got %h exp 00001", BCD); end
    checks++; if (Negative !== 1'b1) begin errors++; $display("FAIL neg1_neg got %b exp 1", Negative); end
    checks++; if (DigitEn !== 5'b00001) begin errors++; $display("FAIL neg1_en got %b exp 00001", DigitEn); end
  endtask

  task automatic test_extremes;
    int cyc, bc; bit seen;
    start_conv(16'h8000);
    wait_done(cyc, bc, seen);
    checks++; if (!seen) begin errors++; $display("FAIL min_timeout no Done within 40 cycles"); end
    checks++; if (BCD !== 20'h32768) begin errors++; $display("FAIL min_bcd got %h exp 32768", BCD); end
    checks++; if (Negative !== 1'b1) begin errors++; $display("FAIL min_neg got %b exp 1", Negative); end
    checks++; if (DigitEn !== 5'b11111) begin errors++; $display("FAIL min_en got %b exp 11111", DigitEn); end
    start_conv(16'h7FFF);
    wait_done(cyc, bc, seen);
    checks++; if (!seen) begin errors++; $display("FAIL max_timeout no Done within 40 cycles"); end
    checks++; if (BCD !== 20'h32767) begin errors++; $display("FAIL max_bcd got %h exp 32767", BCD); end
    checks++; if (Negative !== 1'b0) begin errors++; $display("FAIL max_neg got %b exp 0", Negative); end
  endtask

  task automatic test_back_to_back;
    int done_cnt;
    // 0x0457 = 1111; a second Start with 0x1234 mid-conversion must be dropped.
    start_conv(16'h0457);
    repeat (4) @(negedge Clk);
    Start   = 1'b1;
    Product = 16'h1234;
    @(negedge Clk);
    Start   = 1'b0;
    Product = 16'h0000;
    done_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      if (Done) done_cnt++;
      @(negedge Clk);
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL b2b_done_pulses got %0d exp 1", done_cnt); end
    checks++; if (BCD !== 20'h01111) begin errors++; $display("FAIL b2b_bcd got %h exp 01111", BCD); end
    checks++; if (DigitEn !== 5'b01111) begin errors++; $display("FAIL b2b_en got %b exp 01111", DigitEn); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got %b exp 0", Busy); end
  endtask

  task automatic test_reset_abort;
    int cyc, bc, done_cnt; bit seen;
    start_conv(16'hFFCF);
    wait_done(cyc, bc, seen);
    checks++; if (BCD !== 20'h00049) begin errors++; $display("FAIL abort_prior_bcd got %h exp 00049", BCD); end
    start_conv(16'h3039);
    repeat (7) @(negedge Clk);
    Reset = 1'b1;
    #1;
    checks++; if (BCD !== 20'h00000) begin errors++; $display("FAIL abort_bcd got %h exp 00000", BCD); end
    checks++; if (Negative !== 1'b0) begin errors++; $display("FAIL abort_neg got %b exp 0", Negative); end
    checks++; if (DigitEn !== 5'b00001) begin errors++; $display("FAIL abort_en got %b exp 00001", DigitEn); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", Busy); end
    @(negedge Clk);
    Reset = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (Done) done_cnt++;
      @(negedge Clk);
    end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", done_cnt); end
    checks++; if (BCD !== 20'h00000) begin errors++; $display("FAIL abort_hold_bcd got %h exp 00000", BCD); end
    start_conv(16'h2710);
    wait_done(cyc, bc, seen);
    checks++; if (!seen) begin errors++; $display("FAIL after_timeout no Done within 40 cycles"); end
    checks++; if (cyc != 16) begin errors++; $display("FAIL after_latency got %0d exp 16", cyc); end
    checks++; if (BCD !== 20'h10000) begin errors++; $display("FAIL after_bcd got %h exp 10000", BCD); end
    checks++; if (DigitEn !== 5'b11111) begin errors++; $display("FAIL after_en got %b exp 11111", DigitEn); end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    Reset   = 1'b1;
    Start   = 1'b0;
    Product = 16'h0000;
    test_reset();
    test_zero();
    test_positive();
    test_negative();
    test_extremes();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
